dec_sci_sequencer: RTL and testbench

//  Sequential controller that converts a fixed-point value into a decimal

---
 rtl/dec_sci_pkg.sv | 14 +
 rtl/div10_step.sv | 9 +
 rtl/dec_sci_sequencer.sv | 129 ++++++++++++
 tb/tb_dec_sci_sequencer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dec_sci_pkg.sv
// dec_sci_pkg: shared types and constants for the decimal scientific-notation sequencer
package dec_sci_pkg;
  localparam int INT_DIGITS  = 8;
  localparam int FRAC_DIGITS = 7;
  localparam int MANT_DIGITS = 6;
  localparam int NUM_DIGITS  = INT_DIGITS + FRAC_DIGITS;
  localparam int LAST_IDX    = MANT_DIGITS + 5;
  typedef enum logic [1:0] {IDLE, CONV, NORM, EMIT} state_e;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
endpackage

// File: rtl/div10_step.sv
// div10_step: combinational 24-bit divide by ten with remainder
module div10_step (
  input  logic [23:0] x_i,
  output logic [23:0] q_o,
  output logic [3:0]  r_o
);
  assign q_o = x_i / 24'd10;
  assign r_o = 4'(x_i - q_o * 24'd10);
endmodule

// File: rtl/dec_sci_sequencer.sv
// dec_sci_sequencer: fixed-point to "d.ddddddE+nn" ASCII streamer over valid/ready
module dec_sci_sequencer
  import dec_sci_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] int_val,
  input  logic [22:0] frac_val,
  output logic        busy,
  output logic        ch_valid,
  input  logic        ch_ready,
  output logic [7:0]  ch_data,
  output logic        ch_last,
  output logic        done,
  output logic [7:0]  exp_val,
  output logic [7:0]  exp_sign
);
  state_e state_q, state_d;
  logic [23:0] int_q, frac_q, int_quo, frac_quo;
  logic [3:0] int_rem, frac_rem, cnt_q;
  logic [INT_DIGITS-1:0][3:0] int_dig_q;
  logic [FRAC_DIGITS-1:0][3:0] frac_dig_q;
  logic [4:0] lead_q, lead_d, pos;
  logic any_nz, acc, ch_valid_q, ch_last_q, done_q;
  logic [7:0] exp_val_q, exp_sign_q, exp_mag_d, sign_d, ch_data_q, ch_nxt;
  logic [3:0] d [32];
  div10_step u_int_div (.x_i(int_q), .q_o(int_quo), .r_o(int_rem));
  div10_step u_frac_div (.x_i(frac_q), .q_o(frac_quo), .r_o(frac_rem));
  // D laid out MS-first and zero-padded so mantissa reads past the end yield '0'
  always_comb begin
    for (int i = 0; i < 32; i++) d[i] = 4'd0;
    for (int i = 0; i < INT_DIGITS; i++) d[i] = int_dig_q[INT_DIGITS-1-i];
    for (int j = 0; j < FRAC_DIGITS; j++) d[INT_DIGITS+j] = frac_dig_q[FRAC_DIGITS-1-j];
  end
  always_comb begin
    lead_d = '0;
    any_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (d[i] != 4'd0) begin
        lead_d = 5'(i);
        any_nz = 1'b1;
      end
    end
    exp_mag_d = !any_nz ? 8'd0 : lead_d < 5'(INT_DIGITS) ? 8'(INT_DIGITS - 1) - 8'(lead_d)
                                                         : 8'(lead_d) - 8'(INT_DIGITS - 1);
    sign_d = (any_nz && lead_d >= 5'(INT_DIGITS)) ? CH_MINUS : CH_PLUS;
  end
  assign pos = lead_q + 5'(cnt_q) - 5'd1;
  assign acc = ch_valid_q & ch_ready;
  assign ch_nxt = cnt_q == 4'd0 ? CH_0 + {4'd0, d[lead_q]} :
                  cnt_q == 4'd1 ? CH_DOT :
                  cnt_q <= 4'(MANT_DIGITS + 1) ? CH_0 + {4'd0, d[pos]} :
                  cnt_q == 4'(MANT_DIGITS + 2) ? CH_E :
                  cnt_q == 4'(MANT_DIGITS + 3) ? exp_sign_q :
                  cnt_q == 4'(MANT_DIGITS + 4) ? CH_0 + exp_val_q / 8'd10 :
                                                 CH_0 + exp_val_q % 8'd10;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && start)                         ? CONV :
              (state_q == CONV && cnt_q == 4'(INT_DIGITS - 1))   ? NORM :
              (state_q == NORM)                                  ? EMIT :
              (state_q == EMIT && acc && ch_last_q)              ? IDLE : state_q;
  end
  always_comb begin
    busy     = state_q != IDLE;
    ch_valid = ch_valid_q;
    ch_data  = ch_data_q;
    ch_last  = ch_last_q;
    done     = done_q;
    exp_val  = exp_val_q;
    exp_sign = exp_sign_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q      <= '0;
      frac_q     <= '0;
      int_dig_q  <= '0;
      frac_dig_q <= '0;
      cnt_q      <= '0;
      lead_q     <= '0;
      exp_val_q  <= '0;
      exp_sign_q <= CH_PLUS;
      ch_valid_q <= 1'b0;
      ch_last_q  <= 1'b0;
      ch_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          int_q  <= int_val;
          frac_q <= {1'b0, frac_val};
          cnt_q  <= '0;
        end
        CONV: begin
          int_q     <= int_quo;
          int_dig_q <= {int_rem, int_dig_q[INT_DIGITS-1:1]};
          if (cnt_q < 4'(FRAC_DIGITS)) begin
            frac_q     <= frac_quo;
            frac_dig_q <= {frac_rem, frac_dig_q[FRAC_DIGITS-1:1]};
          end
          cnt_q <= cnt_q + 4'd1;
        end
        NORM: begin
          lead_q     <= lead_d;
          exp_val_q  <= exp_mag_d;
          exp_sign_q <= sign_d;
          cnt_q      <= '0;
        end
        EMIT: if (acc && ch_last_q) begin
          ch_valid_q <= 1'b0;
          ch_last_q  <= 1'b0;
          ch_data_q  <= '0;
          done_q     <= 1'b1;
        end else if (!ch_valid_q || ch_ready) begin
          ch_valid_q <= 1'b1;
          ch_data_q  <= ch_nxt;
          ch_last_q  <= cnt_q == 4'(LAST_IDX);
          cnt_q      <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dec_sci_sequencer.sv
// tb_dec_sci_sequencer: directed vectors for the scientific-notation sequencer
module tb_dec_sci_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ch_ready = 1'b1;
  logic [23:0] int_val = '0;
  logic [22:0] frac_val = '0;
  logic        busy, ch_valid, ch_last, done;
  logic [7:0]  ch_data, exp_val, exp_sign;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  dec_sci_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .int_val(int_val), .frac_val(frac_val),
    .busy(busy), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .ch_last(ch_last), .done(done), .exp_val(exp_val), .exp_sign(exp_sign)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, ch_valid, 0);
    check({tag, "_last"}, ch_last, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data"}, ch_data, 8'h00);
    check({tag, "_expv"}, exp_val, 0);
    check({tag, "_exps"}, exp_sign, 8'h2B);
  endtask
  task automatic do_start(input logic [23:0] iv, input logic [22:0] fv);
    @(posedge clk); #1;
    int_val = iv;
    frac_val = fv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic recv(input string s, input int stall_at, input int abort_at);
    int got = 0;
    int cyc = 0;
    bit stalled = 0;
    while (got < 12 && cyc < 200) begin
      if (got == abort_at && ch_valid) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      if (got == stall_at && !stalled && ch_valid) begin
        stalled = 1;
        ch_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check("stall_valid", ch_valid, 1);
          check("stall_data", ch_data, s[got]);
          start = (k == 1);
          int_val = 24'd999;
        end
        start = 1'b0;
        ch_ready = 1'b1;
      end
      if (ch_valid && ch_ready) begin
        check($sformatf("char%0d", got), ch_data, s[got]);
        check($sformatf("last%0d", got), ch_last, got == 11);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("char_count", got, 12);
    check("done_hi", done, 1);
    check("busy_end", busy, 0);
    check("valid_end", ch_valid, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
  endtask
  initial begin
    int lat;
    int extra;
    #12;
    check_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_start(24'd10, 23'd5000000);
    check("busy_start", busy, 1);
    lat = 0;
    while (!ch_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 10);
    recv("1.050000E+01", -1, -1);
    check("t1_expv", exp_val, 1);
    check("t1_exps", exp_sign, 8'h2B);
    do_start(24'd0, 23'd12345);
    recv("1.234500E-03", -1, -1);
    check("t2_expv", exp_val, 3);
    check("t2_exps", exp_sign, 8'h2D);
    do_start(24'd0, 23'd0);
    recv("0.000000E+00", -1, -1);
    check("t3_expv", exp_val, 0);
    check("t3_exps", exp_sign, 8'h2B);
    do_start(24'd16777215, 23'd8388607);
    recv("1.677721E+07", -1, -1);
    check("t4_expv", exp_val, 7);
    do_start(24'd12345, 23'd678);
    recv("1.234500E+04", 4, -1);
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ch_valid || busy || done) extra++;
    end
    check("no_second_string", extra, 0);
    check("t5_expv", exp_val, 4);
    do_start(24'd10, 23'd5000000);
    recv("1.050000E+01", -1, 6);
    check_reset_outs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("abort_quiet", extra, 0);
    do_start(24'd36, 23'd0);
    recv("3.600000E+01", -1, -1);
    check("t6_expv", exp_val, 1);
    check("t6_exps", exp_sign, 8'h2B);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
